// File: rtl/scancode_matrix_mapper.sv
// PS/2 make/break events -> reference-counted key matrix through per-lane keymap RAMs (CPU loadable).
// Matrix settles 3+KPC cycles after an idle strobe; one-deep latches drop extra strobes and flag overrun.
module scancode_matrix_mapper #(
  parameter int ROWS     = 8,
  parameter int COLS     = 5,
  parameter int KPC      = 2,
  parameter int MOD_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_scan_received,
  input  logic [6:0]          i_scan,
  input  logic                i_extended,
  input  logic                i_released,
  input  logic [MOD_BITS-1:0] i_mods,
  input  logic                i_clear,
  input  logic [ROWS-1:0]     i_sp_row,
  output logic [COLS-1:0]     o_sp_col,
  input  logic                i_cpu_rewind,
  input  logic                i_cpu_rd,
  input  logic                i_cpu_wr,
  input  logic [7:0]          i_din,
  output logic [7:0]          o_dout,
  output logic                o_dout_valid,
  output logic                o_busy,
  output logic                o_overrun
);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int EW     = ROW_W + COLS;
  localparam int DW     = MOD_BITS + 8;
  localparam int DEPTH  = 1 << DW;
  localparam int LANE_W = $clog2(KPC);
  localparam int LW1    = (LANE_W > 0) ? LANE_W : 1;
  localparam int AW     = DW + LANE_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_READ, S_APPLY, S_CPU} state_t;
  state_t r_state, w_state_nxt;

  logic                r_ev_vld, r_ev_ext, r_ev_rel;
  logic [6:0]          r_ev_scan;
  logic [MOD_BITS-1:0] r_ev_mods;
  logic                r_rew_vld, r_rd_vld, r_wr_vld;
  logic [EW-1:0]       r_wr_dat;
  logic [AW-1:0]       r_cpu_addr;
  logic [255:0]        r_keydown;
  logic [MOD_BITS-1:0] r_pmod [256];
  logic [DW-1:0]       r_addr;
  logic                r_rel;
  logic [LW1-1:0]      r_lane, r_rd_lane;
  logic [1:0]          r_cnt [ROWS][COLS];
  logic                r_rd_pend, r_dout_vld, r_overrun;
  logic [7:0]          r_dout;

  logic [7:0]          w_key;
  logic                w_discard, w_ev_take, w_wr_in, w_drop;
  logic                w_do_rew, w_do_rd, w_do_wr;
  logic [MOD_BITS-1:0] w_lk_mods;
  logic [DW-1:0]       w_cpu_entry, w_ram_raddr;
  logic [LW1-1:0]      w_cpu_lane;
  logic [EW-1:0]       w_lane_q [KPC];
  logic [EW-1:0]       w_apply_ent;
  logic [ROW_W-1:0]    w_apply_row;
  logic [COLS-1:0]     w_apply_mask;

  assign w_key     = {r_ev_ext, r_ev_scan};
  // A make needs the key up, a break needs it down; anything else is typematic noise.
  assign w_discard = (r_ev_rel != r_keydown[w_key]);
  assign w_lk_mods = r_ev_rel ? r_pmod[w_key] : r_ev_mods;
  assign w_ev_take = (r_state == S_LOOKUP);

  assign w_do_rew    = (r_state == S_CPU) && r_rew_vld;
  assign w_do_rd     = (r_state == S_CPU) && !r_rew_vld && r_rd_vld;
  assign w_do_wr     = (r_state == S_CPU) && !r_rew_vld && !r_rd_vld && r_wr_vld;
  assign w_cpu_entry = r_cpu_addr[AW-1 -: DW];
  assign w_cpu_lane  = LW1'(r_cpu_addr % AW'(KPC));
  assign w_ram_raddr = (r_state == S_CPU) ? w_cpu_entry : r_addr;

  assign w_wr_in = i_cpu_wr && !i_cpu_rd;
  assign w_drop  = (i_scan_received && r_ev_vld && !w_ev_take) || (i_cpu_rewind && r_rew_vld) ||
                   (i_cpu_rd && r_rd_vld) || (w_wr_in && r_wr_vld) || (i_cpu_rd && i_cpu_wr);

  assign w_apply_ent  = w_lane_q[r_lane];
  assign w_apply_row  = w_apply_ent[EW-1:COLS];
  assign w_apply_mask = w_apply_ent[COLS-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_ev_vld) w_state_nxt = S_LOOKUP;
                else if (r_rew_vld || r_rd_vld || r_wr_vld) w_state_nxt = S_CPU;
      S_LOOKUP: w_state_nxt = w_discard ? S_IDLE : S_READ;
      S_READ:   w_state_nxt = S_APPLY;
      S_APPLY:  if (r_lane == LW1'(KPC - 1)) w_state_nxt = S_IDLE;
      S_CPU:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // CPU ops are single-cycle, so forcing IDLE never tears a write.
    if (i_clear) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
    if (r_state == S_READ)       r_lane <= '0;
    else if (r_state == S_APPLY) r_lane <= r_lane + LW1'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_vld <= 1'b0;
    end else if (i_scan_received && (!r_ev_vld || w_ev_take)) begin
      r_ev_vld  <= 1'b1;
      r_ev_scan <= i_scan;
      r_ev_ext  <= i_extended;
      r_ev_rel  <= i_released;
      r_ev_mods <= i_mods;
    end else if (w_ev_take) begin
      r_ev_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rew_vld <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_wr_vld  <= 1'b0;
    end else begin
      if (i_cpu_rewind && !r_rew_vld) r_rew_vld <= 1'b1;
      else if (w_do_rew)              r_rew_vld <= 1'b0;
      if (i_cpu_rd && !r_rd_vld)      r_rd_vld <= 1'b1;
      else if (w_do_rd)               r_rd_vld <= 1'b0;
      if (w_wr_in && !r_wr_vld) begin
        r_wr_vld <= 1'b1;
        r_wr_dat <= i_din[EW-1:0];
      end else if (w_do_wr) begin
        r_wr_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_do_rew)        r_cpu_addr <= '0;
    else if (w_do_rd || w_do_wr) r_cpu_addr <= r_cpu_addr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear)                   r_keydown <= '0;
    else if (w_ev_take && !w_discard)     r_keydown[w_key] <= !r_ev_rel;
    if (w_ev_take && !w_discard && !r_ev_rel) r_pmod[w_key] <= r_ev_mods;
    if (w_ev_take) begin
      r_addr <= {w_lk_mods, r_ev_ext, r_ev_scan};
      r_rel  <= r_ev_rel;
    end
  end

  for (genvar k = 0; k < KPC; k++) begin : g_lane
    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_q;
    always_ff @(posedge clk) begin
      if (w_do_wr && (w_cpu_lane == LW1'(k))) r_mem[w_cpu_entry] <= r_wr_dat;
      r_q <= r_mem[w_ram_raddr];
    end
    assign w_lane_q[k] = r_q;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rst || i_clear) begin
          r_cnt[r][c] <= 2'd0;
        end else if (r_state == S_APPLY && w_apply_row == ROW_W'(r) && w_apply_mask[c]) begin
          if (!r_rel && r_cnt[r][c] != 2'd3)     r_cnt[r][c] <= r_cnt[r][c] + 2'd1;
          else if (r_rel && r_cnt[r][c] != 2'd0) r_cnt[r][c] <= r_cnt[r][c] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    o_sp_col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!i_sp_row[r] && r_cnt[r][c] != 2'd0) o_sp_col[c] = 1'b0;
  end

  // The RAM read lands one cycle after the CPU state; the lane is remembered past the address bump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_rd_pend  <= w_do_rd;
      r_dout_vld <= r_rd_pend;
      if (r_rd_pend) r_dout <= 8'(w_lane_q[r_rd_lane]);
      r_overrun  <= (r_overrun && !i_clear) || w_drop;
    end
    r_rd_lane <= w_cpu_lane;
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_vld;
  assign o_busy       = (r_state != S_IDLE);
  assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_scancode_matrix_mapper.sv
// Table-driven directed vectors plus randomized events checked against a keymap/press-count model.
module tb_scancode_matrix_mapper;
  logic       clk = 1'b0;
  logic       rst, i_scan_received, i_extended, i_released, i_clear;
  logic [6:0] i_scan;
  logic [2:0] i_mods;
  logic [7:0] i_sp_row, i_din, o_dout;
  logic [4:0] o_sp_col;
  logic       i_cpu_rewind, i_cpu_rd, i_cpu_wr, o_dout_valid, o_busy, o_overrun;

  always #5 clk = ~clk;

  scancode_matrix_mapper dut (
    .clk(clk), .rst(rst), .i_scan_received(i_scan_received), .i_scan(i_scan),
    .i_extended(i_extended), .i_released(i_released), .i_mods(i_mods), .i_clear(i_clear),
    .i_sp_row(i_sp_row), .o_sp_col(o_sp_col), .i_cpu_rewind(i_cpu_rewind), .i_cpu_rd(i_cpu_rd),
    .i_cpu_wr(i_cpu_wr), .i_din(i_din), .o_dout(o_dout), .o_dout_valid(o_dout_valid),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: keymap contents, per-key press counts, per-scancode down flag and press modifiers.
  bit [7:0] mmap [2][2048];
  int       cnt [8][5];
  bit       kd [256];
  bit [2:0] pm [256];
  int       cpu_addr_m = 0;

  typedef struct {
    bit [6:0] scan;
    bit       rel;
    bit [2:0] mods;
    bit [7:0] row;
    bit [4:0] exp;
    string    name;
  } vec_t;
  vec_t vt [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void m_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) cnt[r][c] = 0;
    for (int k = 0; k < 256; k++) kd[k] = 1'b0;
  endfunction

  function automatic void m_event(bit [6:0] s, bit e, bit r, bit [2:0] m);
    int key, mm, ent, v, row;
    key = {e, s};
    if (r != kd[key]) return;
    mm = r ? int'(pm[key]) : int'(m);
    if (!r) pm[key] = m;
    kd[key] = !r;
    ent = mm * 256 + key;
    for (int l = 0; l < 2; l++) begin
      v = mmap[l][ent];
      row = v / 32;
      for (int c = 0; c < 5; c++) begin
        if (((v >> c) & 1) != 0) begin
          if (r) begin
            if (cnt[row][c] > 0) cnt[row][c]--;
          end else if (cnt[row][c] < 3) begin
            cnt[row][c]++;
          end
        end
      end
    end
  endfunction

  function automatic bit [4:0] m_col(bit [7:0] sel);
    bit [4:0] res;
    res = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!sel[r] && cnt[r][c] != 0) res[c] = 1'b0;
    return res;
  endfunction

  task automatic send_event(bit [6:0] s, bit e, bit r, bit [2:0] m);
    i_scan = s; i_extended = e; i_released = r; i_mods = m;
    i_scan_received = 1'b1;
    tick();
    i_scan_received = 1'b0;
    m_event(s, e, r, m);
  endtask

  task automatic do_event(bit [6:0] s, bit e, bit r, bit [2:0] m);
    send_event(s, e, r, m);
    repeat (5) tick();
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    m_clear();
  endtask

  task automatic cpu_rewind();
    i_cpu_rewind = 1'b1;
    tick();
    i_cpu_rewind = 1'b0;
    repeat (2) tick();
    cpu_addr_m = 0;
  endtask

  task automatic cpu_write(bit [7:0] d);
    i_din = d;
    i_cpu_wr = 1'b1;
    tick();
    i_cpu_wr = 1'b0;
    repeat (2) tick();
    mmap[cpu_addr_m % 2][cpu_addr_m / 2] = d;
    cpu_addr_m = (cpu_addr_m + 1) % 4096;
  endtask

  // Issues a read strobe (optionally with a write on the same edge) and watches a bounded window.
  task automatic cpu_read(string name, bit [7:0] exp, bit with_wr);
    int pulses;
    logic [7:0] seen;
    pulses = 0;
    seen = 8'h00;
    i_din = 8'h77;
    i_cpu_rd = 1'b1;
    i_cpu_wr = with_wr;
    tick();
    i_cpu_rd = 1'b0;
    i_cpu_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_dout_valid) begin
        pulses++;
        seen = o_dout;
      end
      tick();
    end
    check({name, "_pulses"}, pulses, 1);
    check({name, "_dout"}, seen, exp);
    cpu_addr_m = (cpu_addr_m + 1) % 4096;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [6:0] s;
    bit [7:0] sel;
    rst = 1'b1; i_scan_received = 1'b0; i_scan = '0; i_extended = 1'b0; i_released = 1'b0;
    i_mods = '0; i_clear = 1'b0; i_sp_row = 8'h00; i_cpu_rewind = 1'b0; i_cpu_rd = 1'b0;
    i_cpu_wr = 1'b0; i_din = '0;
    m_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_sp_col", o_sp_col, 5'h1F);
    check("rst_busy", o_busy, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_dout", o_dout, 8'h00);
    check("rst_dout_valid", o_dout_valid, 1'b0);

    mmap[0][12'h01C] = 8'h21;  // 'A' -> row 1 col 0
    mmap[0][12'h11E] = 8'h62;  // shift+'2' -> row 3 col 1
    mmap[0][12'h01E] = 8'h84;  // plain '2' -> row 4 col 2
    mmap[0][12'h015] = 8'hE1;  // row 7 col 0
    mmap[1][12'h01D] = 8'hE1;  // row 7 col 0 via lane 1
    for (int m = 0; m < 8; m++)
      for (int k = 8'h30; k < 8'h38; k++)
        for (int l = 0; l < 2; l++) mmap[l][m * 256 + k] = 8'($urandom_range(0, 255));
    cpu_rewind();
    for (int a = 0; a < 4096; a++) cpu_write(mmap[a % 2][a / 2]);
    check("load_overrun", o_overrun, 1'b0);

    i_sp_row = 8'hFD;
    send_event(7'h1C, 1'b0, 1'b0, 3'd0);
    repeat (4) tick();
    check("lat_busy_before", o_busy, 1'b1);
    tick();
    check("lat_busy_after", o_busy, 1'b0);
    check("lat_makeA", o_sp_col, 5'b11110);
    do_event(7'h1C, 1'b0, 1'b1, 3'd0);

    vt[0]  = '{7'h1C, 1'b0, 3'd0, 8'hFD, 5'b11110, "makeA"};
    vt[1]  = '{7'h1C, 1'b1, 3'd0, 8'hFD, 5'b11111, "breakA"};
    vt[2]  = '{7'h1E, 1'b0, 3'd1, 8'hF7, 5'b11101, "make_shift2"};
    vt[3]  = '{7'h1E, 1'b1, 3'd0, 8'hF7, 5'b11111, "break2_pmod"};
    vt[4]  = '{7'h1C, 1'b0, 3'd0, 8'hFD, 5'b11110, "typ_make1"};
    vt[5]  = '{7'h1C, 1'b0, 3'd0, 8'hFD, 5'b11110, "typ_make2"};
    vt[6]  = '{7'h1C, 1'b0, 3'd0, 8'hFD, 5'b11110, "typ_make3"};
    vt[7]  = '{7'h1C, 1'b1, 3'd0, 8'hFD, 5'b11111, "typ_break"};
    vt[8]  = '{7'h15, 1'b0, 3'd0, 8'h7F, 5'b11110, "ovl_make1"};
    vt[9]  = '{7'h1D, 1'b0, 3'd0, 8'h7F, 5'b11110, "ovl_make2"};
    vt[10] = '{7'h15, 1'b1, 3'd0, 8'h7F, 5'b11110, "ovl_break1"};
    vt[11] = '{7'h1D, 1'b1, 3'd0, 8'h7F, 5'b11111, "ovl_break2"};
    for (int i = 0; i < 12; i++) begin
      i_sp_row = vt[i].row;
      do_event(vt[i].scan, 1'b0, vt[i].rel, vt[i].mods);
      check(vt[i].name, o_sp_col, vt[i].exp);
    end

    for (int i = 0; i < 300; i++) begin
      s = 7'(8'h30 + $urandom_range(0, 7));
      do_event(s, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      sel = 8'($urandom_range(0, 255));
      i_sp_row = sel;
      #1;
      check("rand_sp_col", o_sp_col, m_col(sel));
      if (i % 60 == 59) begin
        do_clear();
        i_sp_row = 8'h00;
        #1;
        check("rand_clear", o_sp_col, 5'h1F);
      end
    end

    do_clear();
    send_event(7'h15, 1'b0, 1'b0, 3'd0);
    i_scan = 7'h1C; i_released = 1'b0; i_mods = 3'd0; i_scan_received = 1'b1;
    tick();
    i_scan_received = 1'b0;
    repeat (6) tick();
    check("ovr_set", o_overrun, 1'b1);
    i_sp_row = 8'hFD;
    #1;
    check("ovr_dropped_A", o_sp_col, 5'b11111);
    i_sp_row = 8'h7F;
    #1;
    check("ovr_kept_first", o_sp_col, 5'b11110);
    do_clear();
    i_sp_row = 8'h00;
    #1;
    check("clr_sp_col", o_sp_col, 5'h1F);
    check("clr_overrun", o_overrun, 1'b0);

    cpu_rewind();
    cpu_write(8'h21);
    cpu_write(8'h42);
    cpu_rewind();
    cpu_read("rd0", 8'h21, 1'b0);
    cpu_read("rd1", 8'h42, 1'b0);
    cpu_read("rdwr", mmap[cpu_addr_m % 2][cpu_addr_m / 2], 1'b1);
    check("rdwr_overrun", o_overrun, 1'b1);
    do_clear();
    check("rdwr_clr_overrun", o_overrun, 1'b0);

    i_sp_row = 8'hFD;
    send_event(7'h1C, 1'b0, 1'b0, 3'd0);
    repeat (4) tick();
    check("mid_apply_lane0", o_sp_col, 5'b11110);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_clear();
    cpu_addr_m = 0;
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_sp_col", o_sp_col, 5'b11111);
    check("rst_mid_dout", o_dout, 8'h00);
    do_event(7'h1C, 1'b0, 1'b0, 3'd0);
    check("post_rst_makeA", o_sp_col, m_col(8'hFD));
    do_event(7'h1C, 1'b0, 1'b1, 3'd0);
    check("post_rst_breakA", o_sp_col, 5'b11111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
